// File: rtl/m_wb_gpio.sv
// -----------------------------------------------------------------------------
// m_wb_gpio
//
// Wishbone classic slave that puts general purpose I/O on the midgetv core bus.
// It provides NOUT registered outputs (LEDs) and NIN asynchronous inputs.
// Each input passes through a 2-FF synchroniser and has sticky rise/fall flags.
// Any set flag raises irq.
//
// Optional feature macro: WBGPIO_PWM_EN
//   defined   : per-output PWM duty register at ADR 3. A free-running PWMBITS
//               counter gates each output.
//   undefined : outputs follow OUT directly. ADR 3 reads 0 and ignores writes.
//
// Ports
//   CLK_I  in   1     clock, all flops on rising edge
//   RST_I  in   1     synchronous reset, active high
//   CYC_I  in   1     bus cycle
//   STB_I  in   1     strobe
//   WE_I   in   1     write enable
//   ADR_I  in   2     word select (bus ADR[3:2])
//   SEL_I  in   4     byte lane enables for writes
//   DAT_I  in   32    write data
//   DAT_O  out  32    read data, valid while ACK_O=1
//   ACK_O  out  1     registered acknowledge
//   gpi    in   NIN   asynchronous inputs
//   gpo    out  NOUT  registered outputs
//   irq    out  1     OR of all edge flags
//
// Register map (ADR_I)
//   0 OUT   rw   [NOUT-1:0]
//   1 IN    ro   synchronised gpi [NIN-1:0]
//   2 EDGE  w1c  rise [NIN-1:0], fall [16+NIN-1:16]
//   3 DUTY  rw   duty of output i at [i*PWMBITS +: PWMBITS] (PWM build only)
// -----------------------------------------------------------------------------
module m_wb_gpio #(
   parameter int NOUT    = 4,
   parameter int NIN     = 1,
   parameter int PWMBITS = 4
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic            CYC_I,
   input  logic            STB_I,
   input  logic            WE_I,
   input  logic [1:0]      ADR_I,
   input  logic [3:0]      SEL_I,
   input  logic [31:0]     DAT_I,
   output logic [31:0]     DAT_O,
   output logic            ACK_O,
   input  logic [NIN-1:0]  gpi,
   output logic [NOUT-1:0] gpo,
   output logic            irq
);

   localparam logic [1:0] ADR_OUT  = 2'd0;
   localparam logic [1:0] ADR_IN   = 2'd1;
   localparam logic [1:0] ADR_EDGE = 2'd2;
   localparam logic [1:0] ADR_DUTY = 2'd3;

   // ---------------------------------------------------------------------------
   // Bus handshake
   // ---------------------------------------------------------------------------
   // Masking with ACK_O gives an idle cycle after every ack. An access held on
   // the bus is therefore accepted at most once every two cycles.
   logic        w_req;
   logic        w_wr;
   logic [31:0] w_be_mask;
   logic [31:0] w_rdata;

   assign w_req     = CYC_I & STB_I & ~ACK_O;
   assign w_wr      = w_req & WE_I;
   assign w_be_mask = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   logic [NOUT-1:0] r_out;
   logic [NOUT-1:0] w_out_next;
   logic [NOUT-1:0] w_gpo_next;

   assign w_out_next = (r_out & ~w_be_mask[NOUT-1:0]) |
                       (DAT_I[NOUT-1:0] & w_be_mask[NOUT-1:0]);

   // ---------------------------------------------------------------------------
   // Input synchroniser and edge detection
   // ---------------------------------------------------------------------------
   logic [NIN-1:0] r_s1;
   logic [NIN-1:0] r_s2;
   logic [NIN-1:0] r_p;
   logic [1:0]     r_warm;
   logic           w_armed;
   logic [NIN-1:0] w_rise;
   logic [NIN-1:0] w_fall;
   logic [NIN-1:0] r_rise_flg;
   logic [NIN-1:0] r_fall_flg;
   logic [NIN-1:0] w_rise_clr;
   logic [NIN-1:0] w_fall_clr;
   logic [NIN-1:0] w_rise_next;
   logic [NIN-1:0] w_fall_next;

   assign w_rise = r_s2 & ~r_p;
   assign w_fall = ~r_s2 & r_p;

   // The chain comes out of reset as all zeros. An input held high through
   // reset would otherwise look like a rising edge while the chain fills.
   // Flags stay disarmed until the counter saturates.
   assign w_armed = (r_warm == 2'd3);

   assign w_rise_clr = (w_wr && ADR_I == ADR_EDGE) ?
                       (DAT_I[NIN-1:0] & w_be_mask[NIN-1:0]) : '0;
   assign w_fall_clr = (w_wr && ADR_I == ADR_EDGE) ?
                       (DAT_I[16 +: NIN] & w_be_mask[16 +: NIN]) : '0;

   // The set term is ORed in after the clear. If a new edge arrives on the
   // same cycle as its w1c, the flag stays set and the edge is not lost.
   assign w_rise_next = (r_rise_flg & ~w_rise_clr) | (w_armed ? w_rise : '0);
   assign w_fall_next = (r_fall_flg & ~w_fall_clr) | (w_armed ? w_fall : '0);

   assign irq = (|r_rise_flg) | (|r_fall_flg);

   // ---------------------------------------------------------------------------
   // Optional PWM
   // ---------------------------------------------------------------------------
`ifdef WBGPIO_PWM_EN
   localparam int DW = NOUT * PWMBITS;

   logic [DW-1:0]      r_duty;
   logic [DW-1:0]      w_duty_next;
   logic [PWMBITS-1:0] r_pwm_cnt;
   logic [NOUT-1:0]    w_pwm_on;

   assign w_duty_next = (r_duty & ~w_be_mask[DW-1:0]) |
                        (DAT_I[DW-1:0] & w_be_mask[DW-1:0]);

   // All-ones duty is a special case meaning solid on. Without it the top
   // count value would leave a one-cycle gap in every period.
   for (genvar gi = 0; gi < NOUT; gi++) begin : g_pwm
      logic [PWMBITS-1:0] w_duty;
      assign w_duty       = r_duty[gi*PWMBITS +: PWMBITS];
      assign w_pwm_on[gi] = (&w_duty) | (r_pwm_cnt < w_duty);
   end

   assign w_gpo_next = r_out & w_pwm_on;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_duty    <= '1;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (w_wr && ADR_I == ADR_DUTY) begin
            r_duty <= w_duty_next;
         end
      end
   end
`else
   assign w_gpo_next = r_out;
`endif

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      case (ADR_I)
         ADR_OUT:  w_rdata[NOUT-1:0] = r_out;
         ADR_IN:   w_rdata[NIN-1:0]  = r_s2;
         ADR_EDGE: begin
            w_rdata[NIN-1:0]  = r_rise_flg;
            w_rdata[16 +: NIN] = r_fall_flg;
         end
`ifdef WBGPIO_PWM_EN
         ADR_DUTY: w_rdata[DW-1:0] = r_duty;
`endif
         default:  w_rdata = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ACK_O      <= 1'b0;
         DAT_O      <= '0;
         r_out      <= '0;
         gpo        <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_p        <= '0;
         r_warm     <= '0;
         r_rise_flg <= '0;
         r_fall_flg <= '0;
      end else begin
         ACK_O <= w_req;
         DAT_O <= w_req ? w_rdata : '0;

         if (w_wr && ADR_I == ADR_OUT) begin
            r_out <= w_out_next;
         end

         // gpo samples the committed OUT value and lags a write by one edge.
         gpo <= w_gpo_next;

         r_s1 <= gpi;
         r_s2 <= r_s1;
         r_p  <= r_s2;
         if (!w_armed) begin
            r_warm <= r_warm + 2'd1;
         end

         r_rise_flg <= w_rise_next;
         r_fall_flg <= w_fall_next;
      end
   end

   // Some DAT_I and byte-mask bits have no destination in a given
   // configuration. Gathering them here makes that explicit.
   logic w_unused;
   assign w_unused = ^{DAT_I, w_be_mask};

endmodule

// File: tb/tb_m_wb_gpio.sv
module tb_m_wb_gpio;

   localparam int NOUT = 4;
   localparam int NIN  = 1;

   logic            CLK_I = 1'b0;
   logic            RST_I;
   logic            CYC_I;
   logic            STB_I;
   logic            WE_I;
   logic [1:0]      ADR_I;
   logic [3:0]      SEL_I;
   logic [31:0]     DAT_I;
   logic [31:0]     DAT_O;
   logic            ACK_O;
   logic [NIN-1:0]  gpi;
   logic [NOUT-1:0] gpo;
   logic            irq;

   m_wb_gpio #(.NOUT(NOUT), .NIN(NIN), .PWMBITS(4)) u_dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .CYC_I (CYC_I),
      .STB_I (STB_I),
      .WE_I  (WE_I),
      .ADR_I (ADR_I),
      .SEL_I (SEL_I),
      .DAT_I (DAT_I),
      .DAT_O (DAT_O),
      .ACK_O (ACK_O),
      .gpi   (gpi),
      .gpo   (gpo),
      .irq   (irq)
   );

   always #5 CLK_I = ~CLK_I;

   typedef struct packed {
      logic        rd;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
   endtask

   // Every ack pops one scoreboard entry. Read entries also check the data.
   always @(negedge CLK_I) begin
      if (ACK_O === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("ack_spurious", {31'b0, ACK_O}, 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.rd) chk("rd_data", DAT_O, e.exp);
         end
      end
   end

   task automatic bus_idle();
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      ADR_I = 2'd0; SEL_I = 4'h0; DAT_I = 32'h0;
   endtask

   // Called just after a rising edge. Returns just after the acking edge.
   task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [31:0] exp);
      bit got;
      sb_q.push_back('{rd: ~we, exp: exp});
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we;
      ADR_I = adr; SEL_I = sel; DAT_I = dat;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge CLK_I); #1;
         if (ACK_O === 1'b1) got = 1;
      end
      if (!got) chk("ack_timeout", 32'(got), 32'd1);
      bus_idle();
   endtask

   task automatic wr(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      wb_xfer(1'b1, adr, sel, dat, 32'h0);
   endtask

   task automatic rd(input logic [1:0] adr, input logic [31:0] exp);
      wb_xfer(1'b0, adr, 4'hF, 32'h0, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge CLK_I); #1; end
   endtask

`ifdef WBGPIO_PWM_EN
   task automatic pwm_count(input logic [31:0] duty, input int exp_hi);
      int hi;
      wr(2'd3, 4'hF, duty);
      tick(20);
      hi = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge CLK_I);
         if (gpo[0]) hi++;
      end
      #1;
      chk("pwm_hi_count", 32'(hi), 32'(exp_hi));
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_idle();
      RST_I = 1'b1;
      gpi   = 1'b1;
      tick(3);
      chk("rst_ack",  {31'b0, ACK_O}, 32'd0);
      chk("rst_dato", DAT_O, 32'd0);
      chk("rst_gpo",  {28'b0, gpo}, 32'd0);
      chk("rst_irq",  {31'b0, irq}, 32'd0);
      RST_I = 1'b0;
      tick(5);

      // Write OUT. gpo follows one edge after the ack.
      wr(2'd0, 4'hF, 32'h5);
      chk("gpo_before", {28'b0, gpo}, 32'h0);
      tick(1);
      chk("gpo_after",  {28'b0, gpo}, 32'h5);
      rd(2'd0, 32'h0000_0005);

      // With SEL=0 the write is acked but has no effect. A held request acks 0,1,0,1.
      tick(1);
      sb_q.push_back('{rd: 1'b0, exp: 32'h0});
      sb_q.push_back('{rd: 1'b0, exp: 32'h0});
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; SEL_I = 4'h0; DAT_I = 32'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK_I);
         chk("ack_pattern", {31'b0, ACK_O}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      bus_idle();
      tick(2);
      chk("gpo_sel0", {28'b0, gpo}, 32'h5);

      // A request without STB, or without CYC, must not be acked or committed.
      tick(1);
      CYC_I = 1'b1; WE_I = 1'b1; SEL_I = 4'hF; DAT_I = 32'hF;
      tick(3);
      CYC_I = 1'b0; STB_I = 1'b1;
      tick(3);
      bus_idle();
      tick(1);
      chk("gpo_nostb", {28'b0, gpo}, 32'h5);

      // Upper OUT bits read as zero. The IN register ignores writes.
      wr(2'd0, 4'hF, 32'hFFFF_FFFF);
      rd(2'd0, 32'h0000_000F);
      wr(2'd1, 4'hF, 32'h0);
      rd(2'd1, 32'h0000_0001);
      wr(2'd0, 4'hF, 32'h5);

      // gpi held high through reset gives no rise flag.
      chk("irq_warm", {31'b0, irq}, 32'd0);
      rd(2'd2, 32'h0);

      gpi = 1'b0;
      tick(5);
      wr(2'd2, 4'hF, 32'h0001_0001);
      rd(2'd2, 32'h0);
      tick(1);
      gpi = 1'b1;
      tick(2);
      chk("irq_e2", {31'b0, irq}, 32'd0);
      tick(1);
      chk("irq_e3", {31'b0, irq}, 32'd1);
      rd(2'd2, 32'h0000_0001);
      gpi = 1'b0;
      tick(4);
      rd(2'd2, 32'h0001_0001);
      rd(2'd1, 32'h0);

      // A w1c on the same edge as a new rise leaves the flag set.
      wr(2'd2, 4'hF, 32'h0001_0001);
      rd(2'd2, 32'h0);
      gpi = 1'b1;
      tick(2);
      wr(2'd2, 4'hF, 32'h1);
      rd(2'd2, 32'h0000_0001);
      chk("irq_setwins", {31'b0, irq}, 32'd1);
      wr(2'd2, 4'hF, 32'h1);
      rd(2'd2, 32'h0);
      chk("irq_cleared", {31'b0, irq}, 32'd0);

      // Reset asserted in the request cycle drops the access.
      tick(1);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; SEL_I = 4'hF; DAT_I = 32'hF;
      RST_I = 1'b1;
      tick(1);
      chk("rst_mid_ack", {31'b0, ACK_O}, 32'd0);
      bus_idle();
      RST_I = 1'b0;
      tick(1);
      chk("rst_mid_gpo", {28'b0, gpo}, 32'h0);
      rd(2'd0, 32'h0);
      tick(4);
      rd(2'd2, 32'h0);
      chk("rst_mid_irq", {31'b0, irq}, 32'd0);

`ifdef WBGPIO_PWM_EN
      wr(2'd0, 4'hF, 32'h1);
      pwm_count(32'h0000_0004, 8);
      pwm_count(32'h0000_000F, 32);
      pwm_count(32'h0000_0000, 0);
      rd(2'd3, 32'h0000_0000);
`else
      wr(2'd3, 4'hF, 32'hFFFF_FFFF);
      rd(2'd3, 32'h0);
`endif

      tick(3);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
